// File: rtl/xmm_wb_pkg.sv
// Shared definitions for the XMM write-back stage: source tags, FP32 field layout
// and the round-robin successor function.
package xmm_wb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_MEM  = 2'b10,
        SRC_FPU  = 2'b11
    } src_t;

    localparam int FP_SIGN_W   = 1;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;
    localparam int FP_W        = FP_SIGN_W + FP_EXP_W + FP_MANT_W;
    localparam int FP_EXP_BIAS = 127;

    // Rotation order ALU -> MEM -> FPU -> ALU
    function automatic src_t next_src(input src_t s);
        case (s)
            SRC_ALU: return SRC_MEM;
            SRC_MEM: return SRC_FPU;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/xmm_writeback_arbiter_fp32_to_fixed.sv
// Combinational FP32 to signed Q-format converter, truncating toward zero with
// saturation; NaN, zero and denormals map to 0.
module fp32_to_fixed
    import xmm_wb_pkg::*;
#(
    parameter int XMM_WIDTH = 64,
    parameter int FRAC_BITS = 15
) (
    input  logic [FP_W-1:0]      fp,
    output logic [XMM_WIDTH-1:0] fixed
);

    // Biased exponent at which |value| reaches 2^(XMM_WIDTH-1-FRAC_BITS)
    localparam int SAT_EXP = FP_EXP_BIAS + XMM_WIDTH - 1 - FRAC_BITS;
    localparam logic [XMM_WIDTH-1:0] POS_SAT = {1'b0, {(XMM_WIDTH-1){1'b1}}};
    localparam logic [XMM_WIDTH-1:0] NEG_SAT = {1'b1, {(XMM_WIDTH-1){1'b0}}};

    logic                 sign;
    logic [FP_EXP_W-1:0]  exp_f;
    logic [FP_MANT_W-1:0] mant;
    logic [XMM_WIDTH-1:0] sig;
    logic [XMM_WIDTH-1:0] mag;
    int                   shift;

    assign sign  = fp[FP_W-1];
    assign exp_f = fp[FP_W-2 -: FP_EXP_W];
    assign mant  = fp[FP_MANT_W-1:0];
    assign sig   = XMM_WIDTH'({1'b1, mant});

    always_comb begin
        shift = int'(exp_f) - FP_EXP_BIAS - FP_MANT_W + FRAC_BITS;
        mag   = '0;
        fixed = '0;
        if (exp_f == '0) begin
            fixed = '0;
        end else if (exp_f == '1) begin
            if (mant == '0)
                fixed = sign ? NEG_SAT : POS_SAT;
        end else if (int'(exp_f) >= SAT_EXP) begin
            fixed = sign ? NEG_SAT : POS_SAT;
        end else begin
            if (shift >= 0)
                mag = sig << shift;
            else
                mag = sig >> (-shift);
            fixed = sign ? -mag : mag;
        end
    end

endmodule

// File: rtl/xmm_writeback_arbiter.sv
// Two-stage XMM write-back: arbitrates ALU/MEM/FPU producers, converts FP32
// payloads to fixed point and issues one register-file write per cycle.
module xmm_writeback_arbiter
    import xmm_wb_pkg::*;
#(
    parameter int XMM_WIDTH  = 64,
    parameter int FRAC_BITS  = 15,
    parameter int REG_ADDR_W = 5,
    parameter int ARB_MODE   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_ADDR_W-1:0]        alu_rd,
    input  logic [31:0]                  alu_res,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_ADDR_W-1:0]        mem_rd,
    input  logic [31:0]                  mem_data,
    input  logic                         fpu_valid,
    output logic                         fpu_ready,
    input  logic [REG_ADDR_W-1:0]        fpu_rd,
    input  logic [XMM_WIDTH-1:0]         fpu_res,
    output logic                         xmm_we,
    output logic [REG_ADDR_W-1:0]        xmm_waddr,
    output logic [XMM_WIDTH-1:0]         xmm_write_data,
    output logic [1:0]                   xmm_src,
    output logic [(2**REG_ADDR_W)-1:0]   pending_mask
);

    src_t                  ptr_q, ptr_d;
    src_t                  grant;
    logic                  accept;
    logic [REG_ADDR_W-1:0] acc_rd;
    logic [XMM_WIDTH-1:0]  acc_data;

    logic                  s1_valid;
    src_t                  s1_src;
    logic [REG_ADDR_W-1:0] s1_rd;
    logic [XMM_WIDTH-1:0]  s1_data;
    logic [XMM_WIDTH-1:0]  conv_data;
    logic [XMM_WIDTH-1:0]  s1_result;

    logic                  s2_valid;
    src_t                  s2_src;
    logic [REG_ADDR_W-1:0] s2_rd;
    logic [XMM_WIDTH-1:0]  s2_data;

    always_comb begin
        grant = SRC_NONE;
        if (ARB_MODE == 0) begin
            if (fpu_valid)      grant = SRC_FPU;
            else if (mem_valid) grant = SRC_MEM;
            else if (alu_valid) grant = SRC_ALU;
        end else begin
            case (ptr_q)
                SRC_MEM: begin
                    if (mem_valid)      grant = SRC_MEM;
                    else if (fpu_valid) grant = SRC_FPU;
                    else if (alu_valid) grant = SRC_ALU;
                end
                SRC_FPU: begin
                    if (fpu_valid)      grant = SRC_FPU;
                    else if (alu_valid) grant = SRC_ALU;
                    else if (mem_valid) grant = SRC_MEM;
                end
                default: begin
                    if (alu_valid)      grant = SRC_ALU;
                    else if (mem_valid) grant = SRC_MEM;
                    else if (fpu_valid) grant = SRC_FPU;
                end
            endcase
        end
    end

    assign accept    = (grant != SRC_NONE);
    assign alu_ready = (grant == SRC_ALU);
    assign mem_ready = (grant == SRC_MEM);
    assign fpu_ready = (grant == SRC_FPU);

    // Pointer advances on every handshake, including one swallowed by flush
    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = next_src(grant);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= SRC_ALU;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        acc_rd   = alu_rd;
        acc_data = XMM_WIDTH'(alu_res);
        case (grant)
            SRC_MEM: begin
                acc_rd   = mem_rd;
                acc_data = XMM_WIDTH'(mem_data);
            end
            SRC_FPU: begin
                acc_rd   = fpu_rd;
                acc_data = fpu_res;
            end
            default: ;
        endcase
    end

    fp32_to_fixed #(
        .XMM_WIDTH (XMM_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .fp    (s1_data[FP_W-1:0]),
        .fixed (conv_data)
    );

    assign s1_result = (s1_src == SRC_FPU) ? s1_data : conv_data;

    // Payload registers load only with a surviving entry so outputs hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src   <= SRC_NONE;
            s1_rd    <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_src   <= SRC_NONE;
            s2_rd    <= '0;
            s2_data  <= '0;
        end else begin
            s1_valid <= accept && !flush;
            s2_valid <= s1_valid && !flush;
            if (accept && !flush) begin
                s1_src  <= grant;
                s1_rd   <= acc_rd;
                s1_data <= acc_data;
            end
            if (s1_valid && !flush) begin
                s2_src  <= s1_src;
                s2_rd   <= s1_rd;
                s2_data <= s1_result;
            end
        end
    end

    assign xmm_we         = s2_valid;
    assign xmm_waddr      = s2_rd;
    assign xmm_write_data = s2_data;
    assign xmm_src        = s2_valid ? s2_src : SRC_NONE;

    always_comb begin
        pending_mask = '0;
        if (s1_valid) pending_mask[s1_rd] = 1'b1;
        if (s2_valid) pending_mask[s2_rd] = 1'b1;
    end

endmodule

// File: tb/tb_xmm_writeback_arbiter.sv
// Bench for xmm_writeback_arbiter: directed scenarios plus randomized traffic
// against a queue-based write model and a real-arithmetic FP32 converter model.
module tb_xmm_writeback_arbiter;

    localparam int W  = 64;
    localparam int F  = 15;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          alu_valid, mem_valid, fpu_valid;
    logic [AW-1:0] alu_rd, mem_rd, fpu_rd;
    logic [31:0]   alu_res, mem_data;
    logic [W-1:0]  fpu_res;

    logic          alu_ready, mem_ready, fpu_ready;
    logic          xmm_we;
    logic [AW-1:0] xmm_waddr;
    logic [W-1:0]  xmm_write_data;
    logic [1:0]    xmm_src;
    logic [31:0]   pending_mask;

    logic          f_alu_ready, f_mem_ready, f_fpu_ready;
    logic          f_xmm_we;
    logic [AW-1:0] f_xmm_waddr;
    logic [W-1:0]  f_xmm_write_data;
    logic [1:0]    f_xmm_src;
    logic [31:0]   f_pending_mask;

    always #5 clk = ~clk;

    xmm_writeback_arbiter #(.XMM_WIDTH(W), .FRAC_BITS(F), .REG_ADDR_W(AW), .ARB_MODE(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_res(alu_res),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_res(fpu_res),
        .xmm_we(xmm_we), .xmm_waddr(xmm_waddr), .xmm_write_data(xmm_write_data),
        .xmm_src(xmm_src), .pending_mask(pending_mask)
    );

    xmm_writeback_arbiter #(.XMM_WIDTH(W), .FRAC_BITS(F), .REG_ADDR_W(AW), .ARB_MODE(0)) dut_fixed (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(f_alu_ready), .alu_rd(alu_rd), .alu_res(alu_res),
        .mem_valid(mem_valid), .mem_ready(f_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .fpu_valid(fpu_valid), .fpu_ready(f_fpu_ready), .fpu_rd(fpu_rd), .fpu_res(fpu_res),
        .xmm_we(f_xmm_we), .xmm_waddr(f_xmm_waddr), .xmm_write_data(f_xmm_write_data),
        .xmm_src(f_xmm_src), .pending_mask(f_pending_mask)
    );

    typedef struct {
        int          due;
        logic [1:0]  src;
        logic [AW-1:0] rd;
        logic [W-1:0]  data;
    } wr_t;

    wr_t           q[$];
    int            ptr;
    int            cyc;
    int            last_grant;
    logic [AW-1:0] last_addr;
    logic [W-1:0]  last_data;
    int            vectors;
    int            miscompares;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference conversion: exact value in real arithmetic, then truncate toward zero
    function automatic logic [W-1:0] fp_to_fix(input logic [31:0] f);
        int     e;
        int     m;
        real    v;
        longint t;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 0) return '0;
        if (e == 255) begin
            if (m != 0) return '0;
            return f[31] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
        v = (8388608.0 + real'(m)) * (2.0 ** real'(e - 150 + F));
        if (v >= 2.0 ** 63.0)
            return f[31] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        t = longint'(v);
        if (real'(t) > v) t = t - 1;
        return f[31] ? 64'(-t) : 64'(t);
    endfunction

    // Source index 0=ALU 1=MEM 2=FPU; -1 when nobody requests
    function automatic int model_grant(input int mode, input logic [2:0] v, input int p);
        if (mode == 0) begin
            for (int i = 2; i >= 0; i--)
                if (v[i]) return i;
            return -1;
        end
        for (int k = 0; k < 3; k++)
            if (v[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int g);
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 5))
            0, 1: f[30:23] = 8'($urandom_range(100, 180));
            2:    f[30:23] = 8'($urandom_range(170, 178));
            3:    f[30:23] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            default: ;
        endcase
        return f;
    endfunction

    // One clock cycle: compare at the falling edge, then advance the model past the rising edge
    task automatic step();
        logic [2:0]  v;
        int          g;
        int          g0;
        logic [31:0] mask;
        wr_t         e;
        @(negedge clk);
        v  = {fpu_valid, mem_valid, alu_valid};
        g  = model_grant(1, v, ptr);
        g0 = model_grant(0, v, 0);
        check("ready_rr", 64'({fpu_ready, mem_ready, alu_ready}), 64'(onehot(g)));
        check("ready_fixed", 64'({f_fpu_ready, f_mem_ready, f_alu_ready}), 64'(onehot(g0)));
        if (q.size() > 0 && q[0].due == cyc) begin
            check("we", 64'(xmm_we), 64'(1));
            check("src", 64'(xmm_src), 64'(q[0].src));
            check("waddr", 64'(xmm_waddr), 64'(q[0].rd));
            check("wdata", xmm_write_data, q[0].data);
            last_addr = q[0].rd;
            last_data = q[0].data;
        end else begin
            check("we_idle", 64'(xmm_we), 64'(0));
            check("src_idle", 64'(xmm_src), 64'(0));
            check("waddr_hold", 64'(xmm_waddr), 64'(last_addr));
            check("wdata_hold", xmm_write_data, last_data);
        end
        mask = '0;
        foreach (q[i]) mask[q[i].rd] = 1'b1;
        check("pending", 64'(pending_mask), 64'(mask));

        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else if (g >= 0) begin
            case (g)
                0:       e = '{cyc + 2, 2'd1, alu_rd, fp_to_fix(alu_res)};
                1:       e = '{cyc + 2, 2'd2, mem_rd, fp_to_fix(mem_data)};
                default: e = '{cyc + 2, 2'd3, fpu_rd, fpu_res};
            endcase
            q.push_back(e);
        end
        if (g >= 0) ptr = (g + 1) % 3;
        last_grant = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [1:0] src, input logic [AW-1:0] rd,
                                input logic [W-1:0] data);
        check({tag, "_we"}, 64'(xmm_we), 64'(1));
        check({tag, "_src"}, 64'(xmm_src), 64'(src));
        check({tag, "_waddr"}, 64'(xmm_waddr), 64'(rd));
        check({tag, "_data"}, xmm_write_data, data);
    endtask

    task automatic model_reset();
        q.delete();
        ptr        = 0;
        last_grant = -1;
        last_addr  = '0;
        last_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    logic [31:0] mem_vec [8];
    logic [W-1:0] mem_exp [8];
    logic [2:0]  rr_exp [4];

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        reset = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; fpu_rd = '0;
        alu_res = '0; mem_data = '0; fpu_res = '0;
        model_reset();

        @(posedge clk);
        #1;
        check("rst_we", 64'(xmm_we), 64'(0));
        check("rst_waddr", 64'(xmm_waddr), 64'(0));
        check("rst_data", xmm_write_data, 64'(0));
        check("rst_src", 64'(xmm_src), 64'(0));
        check("rst_pending", 64'(pending_mask), 64'(0));
        reset = 1'b0;

        // ALU alone: 1.0 to r3
        alu_valid = 1'b1; alu_rd = 5'd3; alu_res = 32'h3F80_0000;
        step();
        alu_valid = 1'b0;
        check("alu_pend_s1", 64'(pending_mask), 64'h8);
        step();
        check("alu_pend_s2", 64'(pending_mask), 64'h8);
        expect_write("alu_one", 2'b01, 5'd3, 64'h0000_0000_0000_8000);
        step();
        check("alu_pend_done", 64'(pending_mask), 64'h0);

        // MEM conversions including saturation and truncation boundaries
        mem_vec[0] = 32'hC020_0000; mem_exp[0] = 64'hFFFF_FFFF_FFFE_C000;
        mem_vec[1] = 32'h7F80_0000; mem_exp[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        mem_vec[2] = 32'h7FC0_0000; mem_exp[2] = 64'h0;
        mem_vec[3] = 32'h0000_0001; mem_exp[3] = 64'h0;
        mem_vec[4] = 32'hFF80_0000; mem_exp[4] = 64'h8000_0000_0000_0000;
        mem_vec[5] = 32'h5780_0000; mem_exp[5] = 64'h7FFF_FFFF_FFFF_FFFF;
        mem_vec[6] = 32'h8000_0000; mem_exp[6] = 64'h0;
        mem_vec[7] = 32'h3800_0000; mem_exp[7] = 64'h1;
        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(i + 8); mem_data = mem_vec[i];
            step();
            mem_valid = 1'b0;
            step();
            expect_write("mem_conv", 2'b10, 5'(i + 8), mem_exp[i]);
            step();
        end

        // Round-robin with all sources requesting
        do_reset();
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_res  = 32'h3F80_0000;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h4000_0000;
        fpu_valid = 1'b1; fpu_rd = 5'd4; fpu_res  = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 64'({fpu_ready, mem_ready, alu_ready}), 64'(rr_exp[k]));
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0;
        expect_write("rr_fpu", 2'b11, 5'd4, 64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < 3; k++) step();

        // Fixed priority: FPU starves the others
        alu_valid = 1'b1; mem_valid = 1'b1; fpu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fixed_grant", 64'({f_fpu_ready, f_mem_ready, f_alu_ready}), 64'(3'b100));
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Accept then flush; a handshake during flush is dropped
        alu_valid = 1'b1; alu_rd = 5'd7; alu_res = 32'h4040_0000;
        step();
        alu_valid = 1'b0; flush = 1'b1; mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h3F80_0000;
        step();
        flush = 1'b0; mem_valid = 1'b0;
        check("flush_we", 64'(xmm_we), 64'(0));
        check("flush_pend", 64'(pending_mask), 64'(0));
        for (int k = 0; k < 3; k++) step();

        // Asynchronous reset while a write is in flight
        alu_valid = 1'b1; alu_rd = 5'd10; alu_res = 32'h4100_0000;
        step();
        alu_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_we", 64'(xmm_we), 64'(0));
        check("arst_waddr", 64'(xmm_waddr), 64'(0));
        check("arst_data", xmm_write_data, 64'(0));
        check("arst_src", 64'(xmm_src), 64'(0));
        check("arst_pend", 64'(pending_mask), 64'(0));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic; requests are held until accepted
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid || last_grant == 0) begin
                alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom); alu_res = rand_fp();
            end
            if (!mem_valid || last_grant == 1) begin
                mem_valid = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom); mem_data = rand_fp();
            end
            if (!fpu_valid || last_grant == 2) begin
                fpu_valid = 1'($urandom_range(0, 1)); fpu_rd = 5'($urandom);
                fpu_res = {$urandom, $urandom};
            end
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
